de_morgan_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively checks two De Morgan gate implementations wired side by side.
  - Form 1 is ~(a|b); form 2 is (~a)&(~b).
- Drives every operand combination, waits a settle window, samples both results, compares them, and counts mismatches.
- Sits between the lab top level (buttons/LEDs) and the two combinational units under check.
- Reports pass/fail, the error count and the first failing vector.

---
 rtl/de_morgan_sweep_ctrl.sv | 129 ++++++++++++
 tb/tb_de_morgan_sweep_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/de_morgan_sweep_ctrl.sv
// Sweep sequencer that drives every {a,b} operand pair into two De Morgan gate forms.
// It compares their results after a settle window and records the error count and first failing vector.
module de_morgan_sweep_ctrl #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  input  logic [WIDTH-1:0]   y_form1,
  input  logic [WIDTH-1:0]   y_form2,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH-1:0] fail_vec,
  output logic               fail_valid
);

  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned EW = IW + 1;
  localparam logic [IW-1:0] LastIdx = {IW{1'b1}};
  localparam logic [3:0] CntLast = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  state_e        r_state, w_state;
  logic [IW-1:0] r_idx, w_idx;
  logic [3:0]    r_cnt, w_cnt;
  logic [EW-1:0] r_err, w_err;
  logic [IW-1:0] r_fail_vec, w_fail_vec;
  logic          r_fail_valid, w_fail_valid;
  logic          r_pass, w_pass;
  logic          w_mismatch;

  assign w_mismatch = (y_form1 != y_form2);

  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_cnt        = r_cnt;
    w_err        = r_err;
    w_fail_vec   = r_fail_vec;
    w_fail_valid = r_fail_valid;
    w_pass       = r_pass;
    unique case (r_state)
      StIdle: begin
        // abort has priority over a coincident start
        if (start && !abort) begin
          w_idx        = '0;
          w_cnt        = '0;
          w_err        = '0;
          w_fail_vec   = '0;
          w_fail_valid = 1'b0;
          w_pass       = 1'b0;
          w_state      = StSettle;
        end
      end
      StSettle: begin
        w_cnt = r_cnt + 4'd1;
        if (abort) begin
          w_pass  = 1'b0;
          w_state = StIdle;
        end else if (r_cnt == CntLast) begin
          w_state = StCheck;
        end
      end
      StCheck: begin
        if (abort) begin
          w_pass  = 1'b0;
          w_state = StIdle;
        end else begin
          if (w_mismatch) begin
            w_err = r_err + EW'(1);
            if (!r_fail_valid) begin
              w_fail_vec   = r_idx;
              w_fail_valid = 1'b1;
            end
          end
          if (r_idx == LastIdx) begin
            w_state = StDone;
          end else begin
            w_idx   = r_idx + IW'(1);
            w_cnt   = '0;
            w_state = StSettle;
          end
        end
      end
      StDone: begin
        w_pass  = (r_err == '0);
        w_state = StIdle;
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fail_vec   <= '0;
      r_fail_valid <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_cnt        <= w_cnt;
      r_err        <= w_err;
      r_fail_vec   <= w_fail_vec;
      r_fail_valid <= w_fail_valid;
      r_pass       <= w_pass;
    end
  end

  assign op_a       = r_idx[IW-1:WIDTH];
  assign op_b       = r_idx[WIDTH-1:0];
  assign busy       = (r_state == StSettle) || (r_state == StCheck);
  assign done       = (r_state == StDone);
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_vec   = r_fail_vec;
  assign fail_valid = r_fail_valid;

endmodule

// File: tb/tb_de_morgan_sweep_ctrl.sv
// Randomized bench for de_morgan_sweep_ctrl: two instances (1-bit/settle 2 and 2-bit/settle 1)
// with bench-driven gate forms, checked against a vector-level sweep model.
module tb_de_morgan_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, start0, abort0, start1, abort1;

  logic [0:0] op_a0, op_b0, y1_0, y2_0;
  logic       busy0, done0, pass0, fv0;
  logic [2:0] err0;
  logic [1:0] fvec0;

  logic [1:0] op_a1, op_b1, y1_1, y2_1;
  logic       busy1, done1, pass1, fv1;
  logic [4:0] err1;
  logic [3:0] fvec1;

  de_morgan_sweep_ctrl #(.WIDTH(1), .SETTLE_CYC(2)) u_dut0 (
    .clk(clk), .resetn(resetn), .start(start0), .abort(abort0),
    .op_a(op_a0), .op_b(op_b0), .y_form1(y1_0), .y_form2(y2_0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_vec(fvec0), .fail_valid(fv0)
  );

  de_morgan_sweep_ctrl #(.WIDTH(2), .SETTLE_CYC(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .abort(abort1),
    .op_a(op_a1), .op_b(op_b1), .y_form1(y1_1), .y_form2(y2_1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_vec(fvec1), .fail_valid(fv1)
  );

  // mode 0: correct NOR xor per-vector fault table; 1: form2 = ~a; 2: stuck-at-0 on bit 1
  int         mode;
  logic [0:0] fault0 [4];
  logic [1:0] fault1 [16];

  always_comb begin
    y1_0 = ~(op_a0 | op_b0);
    y2_0 = (mode == 1) ? ~op_a0 : ((~op_a0 & ~op_b0) ^ fault0[{op_a0, op_b0}]);
    y1_1 = ~(op_a1 | op_b1);
    y2_1 = (mode == 2) ? ((~op_a1 & ~op_b1) & 2'b01)
                       : ((~op_a1 & ~op_b1) ^ fault1[{op_a1, op_b1}]);
  end

  int sel;
  logic [31:0] g_busy, g_done, g_pass, g_err, g_fvec, g_fv, g_vec;
  always_comb begin
    if (sel == 0) begin
      g_busy = 32'(busy0); g_done = 32'(done0); g_pass = 32'(pass0);
      g_err  = 32'(err0);  g_fvec = 32'(fvec0); g_fv   = 32'(fv0);
      g_vec  = 32'({op_a0, op_b0});
    end else begin
      g_busy = 32'(busy1); g_done = 32'(done1); g_pass = 32'(pass1);
      g_err  = 32'(err1);  g_fvec = 32'(fvec1); g_fv   = 32'(fv1);
      g_vec  = 32'({op_a1, op_b1});
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_abort(input int s, input logic v);
    if (s == 0) abort0 = v; else abort1 = v;
  endtask

  // abort_v >= 0 aborts during a SETTLE cycle of that vector
  task automatic run_sweep(input int s, input int abort_v, input bit extra_start,
                           input bit start_in_done);
    int w, st, n, per, len, m, lim, abort_j, exp_err, exp_first, a, b, e1, e2, f;
    bit exp_fv;
    bit mism [16];
    sel = s;
    w = (s == 0) ? 1 : 2;
    st = (s == 0) ? 2 : 1;
    n = 1 << (2 * w);
    per = st + 1;
    len = n * per;
    m = (1 << w) - 1;
    for (int v = 0; v < n; v++) begin
      a = v >> w;
      b = v & m;
      f = (s == 0) ? int'(fault0[v]) : int'(fault1[v]);
      e1 = ~(a | b) & m;
      if (mode == 1) e2 = ~a & m;
      else if (mode == 2) e2 = ~a & ~b & m & 1;
      else e2 = (~a & ~b & m) ^ f;
      mism[v] = (e1 != e2);
    end
    abort_j = -1;
    lim = n;
    if (abort_v >= 0) begin
      abort_j = abort_v * per + 1 + int'($urandom_range(0, st - 1));
      lim = abort_v;
    end
    exp_err = 0; exp_first = 0; exp_fv = 0;
    for (int v = 0; v < lim; v++) begin
      if (mism[v]) begin
        exp_err++;
        if (!exp_fv) begin exp_fv = 1; exp_first = v; end
      end
    end

    @(negedge clk); set_start(s, 1'b1);
    @(negedge clk); set_start(s, 1'b0);
    for (int j = 1; j <= len + 1; j++) begin
      check_eq("busy", g_busy, 32'(j <= len));
      check_eq("done", g_done, 32'(j == len + 1));
      check_eq("op_vec", g_vec, 32'((j <= len) ? (j - 1) / per : n - 1));
      if (j == abort_j) begin
        set_abort(s, 1'b1);
        @(negedge clk); set_abort(s, 1'b0);
        for (int k = 0; k < 3; k++) begin
          check_eq("abort_busy", g_busy, 0);
          check_eq("abort_done", g_done, 0);
          @(negedge clk);
        end
        check_eq("abort_pass", g_pass, 0);
        check_eq("abort_err", g_err, 32'(exp_err));
        check_eq("abort_fv", g_fv, 32'(exp_fv));
        check_eq("abort_fvec", g_fvec, 32'(exp_fv ? exp_first : 0));
        return;
      end
      set_start(s, (extra_start && (j == 4 || j == 8)) || (start_in_done && j == len + 1));
      @(negedge clk);
    end
    set_start(s, 1'b0);
    check_eq("post_busy", g_busy, 0);
    check_eq("post_done", g_done, 0);
    check_eq("pass", g_pass, 32'(exp_err == 0));
    check_eq("err_count", g_err, 32'(exp_err));
    check_eq("fail_valid", g_fv, 32'(exp_fv));
    check_eq("fail_vec", g_fvec, 32'(exp_fv ? exp_first : 0));
    check_eq("hold_vec", g_vec, 32'(n - 1));
    repeat (2) @(negedge clk);
    check_eq("hold_busy", g_busy, 0);
    check_eq("hold_err", g_err, 32'(exp_err));
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 4; i++) fault0[i] = 1'b0;
    for (int i = 0; i < 16; i++) fault1[i] = 2'b00;
  endtask

  initial begin
    resetn = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    mode = 0;
    sel = 0;
    clear_faults();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check_eq("idle_dut0", 32'({op_a0, op_b0, busy0, done0, pass0, err0, fvec0, fv0}), 0);
      check_eq("idle_dut1", 32'({op_a1, op_b1, busy1, done1, pass1, err1, fvec1, fv1}), 0);
    end

    run_sweep(0, -1, 0, 0);
    mode = 1;
    run_sweep(0, -1, 0, 0);
    run_sweep(0, 2, 0, 0);
    mode = 0;
    run_sweep(0, -1, 0, 0);
    run_sweep(0, -1, 1, 0);
    run_sweep(0, -1, 0, 1);

    // abort and start together in IDLE
    sel = 0;
    @(negedge clk); start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk); start0 = 1'b0; abort0 = 1'b0;
    check_eq("abort_start_busy", g_busy, 0);
    @(negedge clk);
    check_eq("abort_start_busy2", g_busy, 0);

    // reset mid-sweep
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    check_eq("midreset_dut0", 32'({op_a0, op_b0, busy0, done0, pass0, err0, fvec0, fv0}), 0);
    repeat (2) @(negedge clk);
    check_eq("midreset_idle", 32'(busy0), 0);

    mode = 2;
    run_sweep(1, -1, 0, 0);
    mode = 0;

    for (int it = 0; it < 12; it++) begin
      int s, av;
      s = int'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) fault0[i] = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      for (int i = 0; i < 16; i++)
        fault1[i] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      av = -1;
      if ($urandom_range(0, 3) == 0) av = int'($urandom_range(0, (s == 0) ? 3 : 15));
      run_sweep(s, av, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
